// File: rtl/stream_arb_sched_if.sv
// Stream-side bundle of the QoS stream arbiter: slave stream inputs, slave readies and the master stream.
// master: scheduler/mux view; slave: stream sources and downstream sink view.
interface stream_arb_sched_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2
) ();
  logic [T_DATA_WIDTH-1:0]         s_data_i [STREAM_COUNT];
  logic [T_QOS__WIDTH-1:0]         s_qos_i  [STREAM_COUNT];
  logic [STREAM_COUNT-1:0]         s_last_i;
  logic [STREAM_COUNT-1:0]         s_valid_i;
  logic [STREAM_COUNT-1:0]         s_ready_o;
  logic [T_DATA_WIDTH-1:0]         m_data_o;
  logic [T_QOS__WIDTH-1:0]         m_qos_o;
  logic [$clog2(STREAM_COUNT)-1:0] m_id_o;
  logic                            m_last_o;
  logic                            m_valid_o;
  logic                            m_ready_i;

  modport master (
    input  s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
  );

  modport slave (
    output s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_arb_sched.sv
// Sequencer and stream mux for the QoS stream arbiter: runs the external max-finder, then forwards the winner's packet.
// Optional stall watchdog: define ARB_WATCHDOG_EN (default build has no watchdog, wdog_err_o tied low).
module stream_arb_sched #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int WDOG_CYCLES  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  stream_arb_sched_if.master              bus,
  output logic                            can_calc_o,
  output logic [STREAM_COUNT-1:0]         served_o,
  input  logic [T_QOS__WIDTH-1:0]         cmp_qos_i,
  input  logic [$clog2(STREAM_COUNT):0]   cmp_index_i,
  output logic                            wdog_err_o
);
  // state | meaning
  // IDLE  | wait for requesters; go to CLEAR when every valid one is already served
  // CLEAR | drop the served mask
  // CALC  | one-cycle comparator enable (its first level is registered)
  // WAIT  | capture comparator winner, or give up when it reports none
  // GRANT | pass the granted stream through until its last beat
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GRANT = 3'd4;

  localparam int IDW = $clog2(STREAM_COUNT);
  localparam logic [IDW:0] IDX_NONE = (IDW + 1)'(STREAM_COUNT);

  logic [2:0]              r_state;
  logic [STREAM_COUNT-1:0] r_served;
  logic [IDW-1:0]          r_grant;
  logic [T_QOS__WIDTH-1:0] r_qos;

  logic w_in_grant;
  logic w_gnt_valid;
  logic w_gnt_last;
  logic w_beat;
  logic w_all_served;
  logic w_wdog_hit;

  assign w_in_grant   = (r_state == S_GRANT);
  assign w_gnt_valid  = bus.s_valid_i[r_grant];
  assign w_gnt_last   = bus.s_last_i[r_grant];
  assign w_beat       = w_in_grant & w_gnt_valid & bus.m_ready_i;
  assign w_all_served = ((r_served & bus.s_valid_i) == bus.s_valid_i);

`ifdef ARB_WATCHDOG_EN
  localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LOAD = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] r_wdog_cnt;

  // Down-counter of consecutive stalled GRANT cycles; terminal count is the last allowed stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= WDOG_LOAD;
    end else if (!w_in_grant || w_gnt_valid || w_wdog_hit) begin
      r_wdog_cnt <= WDOG_LOAD;
    end else begin
      r_wdog_cnt <= r_wdog_cnt - 1'b1;
    end
  end

  assign w_wdog_hit = w_in_grant & ~w_gnt_valid & (r_wdog_cnt == '0);
`else
  // Watchdog compiled out; the expression is constant 0.
  assign w_wdog_hit = (WDOG_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_served <= '0;
      r_grant  <= '0;
      r_qos    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.s_valid_i != '0) begin
            r_state <= w_all_served ? S_CLEAR : S_CALC;
          end
        end
        S_CLEAR: begin
          r_served <= '0;
          r_state  <= S_CALC;
        end
        S_CALC: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (cmp_index_i >= IDX_NONE) begin
            r_state <= S_IDLE;
          end else begin
            r_grant <= cmp_index_i[IDW-1:0];
            r_qos   <= cmp_qos_i;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_wdog_hit || (w_beat && w_gnt_last)) begin
            r_served[r_grant] <= 1'b1;
            r_state           <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.s_ready_o = '0;
    if (w_in_grant) begin
      bus.s_ready_o[r_grant] = bus.m_ready_i;
    end
  end

  assign bus.m_data_o  = w_in_grant ? bus.s_data_i[r_grant] : '0;
  assign bus.m_last_o  = w_in_grant & w_gnt_last;
  assign bus.m_valid_o = w_in_grant & w_gnt_valid;
  assign bus.m_qos_o   = r_qos;
  assign bus.m_id_o    = r_grant;
  assign can_calc_o    = (r_state == S_CALC);
  assign served_o      = r_served;
  assign wdog_err_o    = w_wdog_hit;
endmodule
